checkpoint_recovery_ctrl: RTL and testbench
===========================================

// Module: checkpoint_recovery_ctrl
// PURPOSE
//  Mispredict recovery sequencer downstream of the branch units, upstream of the checkpoint store.
//  Each cycle: forwards correct-branch validations; picks the oldest mispredict; issues a checkpoint recall;
//  unpacks the recalled line; pulses restore data to rename, free list and active list; redirects fetch;
//  holds the front end stalled until flush completes.
// PARAMETERS
//  NUM_PR      64  physical regs; PRW = $clog2(NUM_PR)
//  AL_SIZE     64  active-list entries; ALW = $clog2(AL_SIZE)
//  NUM_CKPT    8   checkpoints; CKW = $clog2(NUM_CKPT)
//  NUM_BR      2   branches resolved per cycle
//  FLUSH_CYC   2   cycles flush is held after restore (>=1)
//  LINE_SIZE   PRW+ALW+NUM_PR+32*PRW  checkpoint line width
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high
//  br_valid       in   [NUM_BR]   branch resolved this cycle
//  br_mispredict  in   [NUM_BR]   resolved branch mispredicted
//  br_cp_id       in   CKW x NUM_BR  checkpoint id of branch
//  br_target      in   32 x NUM_BR   correct next PC
//  cp_front       in   CKW        checkpoint store write pointer (age base)
//  recalled_data  in   LINE_SIZE  checkpoint line; valid same cycle as recall (async read)
//  validate       out  [NUM_BR]   validation to checkpoint store
//  validated_id   out  CKW x NUM_BR
//  recall_ckpt    out  1          recall strobe
//  recall_id      out  CKW
//  restore_valid  out  1          one-cycle restore pulse
//  rmt_restore    out  PRW x 32   restored rename map
//  fl_front_rst   out  PRW        restored free-list head
//  al_front_rst   out  ALW        restored active-list tail
//  bbt_rst        out  NUM_PR     restored busy-bit table
//  redirect_valid out  1          fetch redirect (coincident with restore_valid)
//  redirect_pc    out  32
//  flush          out  1          squash younger in-flight instrs
//  recovery_stall out  1          stall rename/dispatch
// BEHAVIOUR
//  Age: age(id) = (base - 1 - id) mod NUM_CKPT, CKW-bit wrap; larger = older. base = cp_front when idle,
//   latched base_q while busy.
//  validate[i] = br_valid[i] & ~br_mispredict[i] & ~squashed(i); validated_id = br_cp_id; combinational.
//   squashed(i): busy and age(br_cp_id[i]) < age(tgt_id), i.e. younger than pending target.
//  Mispredict select: oldest valid mispredict; age tie -> lower index. Ignored if squashed.
//  FSM IDLE -> RECALL -> RESTORE -> FLUSH(FLUSH_CYC) -> IDLE:
//   IDLE: on selected mispredict latch tgt_id, tgt_pc, base_q <= cp_front; go RECALL.
//   RECALL: recall_ckpt=1, recall_id=tgt_id; register recalled_data into line_q; go RESTORE.
//   RESTORE: restore_valid=1, redirect_valid=1, redirect_pc=tgt_pc, flush=1. Fields from line_q:
//     fl=[PRW-1:0]; al=[PRW+:ALW]; bbt=[PRW+ALW+:NUM_PR];
//     rmt[i]=[PRW+ALW+NUM_PR+i*PRW+:PRW]. Go FLUSH, counter = FLUSH_CYC-1.
//   FLUSH: flush=1; down-count; at 0 go IDLE.
//  Older mispredict while in RECALL/RESTORE/FLUSH: relatch tgt_id/tgt_pc (base_q kept), go RECALL.
//   Restore of older target is pulsed in full; a RESTORE-cycle preemption suppresses that cycle's pulse.
//  recovery_stall = (state != IDLE) | selected mispredict in IDLE (same-cycle stall).
//  Mispredict and validate on same cycle: both handled; validate of a squashed id dropped.
//  Restore fields and redirect_pc hold last value outside restore_valid; consumers qualify on the strobe.
//  Reset (any state): state=IDLE; all strobes (validate, recall_ckpt, restore_valid, redirect_valid,
//   flush, recovery_stall) = 0; line_q, tgt_*, base_q, counters = 0.
// CONFIGURATION
//  RECOVERY_STATS_EN defined: adds outputs stat_recoveries (32b, +1 per restore_valid) and
//   stat_stall_cyc (32b, +1 per recovery_stall cycle); saturating, cleared on reset.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package (core pkg): recov_state_e {IDLE,RECALL,RESTORE,FLUSH}; ckpt_line_t packed struct
//   matching field layout above; PRW/ALW/CKW localparams.
//  Sub-module: ckpt_age_select (combinational oldest-of-NUM_BR picker, age compare vs base).
// TESTING
//  Single mispredict: cp_front=5, br0 mispred id=3, target 0x1000 -> recall id 3 next cycle,
//   restore_valid + redirect_pc=0x1000 cycle after, flush FLUSH_CYC+1 cycles, then IDLE.
//  Dual mispredict same cycle: cp_front=2, ids 0 and 7 -> 7 older, recall_id=7, br0 squashed.
//  Preemption: recovering id 4 (base 6), during FLUSH mispredict id 2 -> RECALL id 2, second restore pulse.
//  Wrap: base=1, ids 0 and 6 -> 6 older; validate for id 0 dropped when target 6 pending.
//  Field unpack: known line pattern (rmt[i]=i, fl=0x2A, al=0x11, bbt=alternating) -> exact outputs.
//  Reset asserted in RESTORE -> next cycle all outputs 0, IDLE; RECOVERY_STATS_EN counts checked.

Source files
------------

// File: rtl/checkpoint_recovery_ctrl_pkg.sv
// Shared types and constants for the checkpoint recovery sequencer.
// Checkpoint line layout from LSB: free-list head, active-list tail, busy bits, rename map.
package checkpoint_recovery_ctrl_pkg;

    localparam int unsigned NUM_PR    = 64;
    localparam int unsigned AL_SIZE   = 64;
    localparam int unsigned NUM_CKPT  = 8;
    localparam int unsigned NUM_BR    = 2;
    localparam int unsigned PRW       = $clog2(NUM_PR);
    localparam int unsigned ALW       = $clog2(AL_SIZE);
    localparam int unsigned CKW       = $clog2(NUM_CKPT);
    localparam int unsigned BRW       = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;
    localparam int unsigned LINE_SIZE = PRW + ALW + NUM_PR + 32 * PRW;

    typedef enum logic [1:0] {IDLE, RECALL, RESTORE, FLUSH} recov_state_e;

    // First member lands in the MSBs, so the rename map comes first.
    typedef struct packed {
        logic [31:0][PRW-1:0] rmt;
        logic [NUM_PR-1:0]    bbt;
        logic [ALW-1:0]       al;
        logic [PRW-1:0]       fl;
    } ckpt_line_t;

    // Distance behind the allocation pointer; larger means older.
    function automatic logic [CKW-1:0] ckpt_age(logic [CKW-1:0] base, logic [CKW-1:0] id);
        logic [CKW-1:0] a;
        a = base - id - CKW'(1);
        return a;
    endfunction

endpackage

// File: rtl/checkpoint_recovery_ctrl_age_select.sv
// Combinational picker: oldest requesting branch relative to an age base.
module ckpt_age_select
    import checkpoint_recovery_ctrl_pkg::*;
(
    input  logic [CKW-1:0]        base,
    input  logic [NUM_BR-1:0]     req,
    input  logic [NUM_BR*CKW-1:0] ids,
    output logic                  sel_valid,
    output logic [BRW-1:0]        sel_idx,
    output logic [CKW-1:0]        sel_id,
    output logic [CKW-1:0]        sel_age
);

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_id    = '0;
        sel_age   = '0;
        // Strict compare keeps the lower index on an age tie.
        for (int i = 0; i < NUM_BR; i++) begin
            if (req[i] && (!sel_valid || ckpt_age(base, ids[i*CKW +: CKW]) > sel_age)) begin
                sel_valid = 1'b1;
                sel_idx   = BRW'(i);
                sel_id    = ids[i*CKW +: CKW];
                sel_age   = ckpt_age(base, ids[i*CKW +: CKW]);
            end
        end
    end

endmodule

// File: rtl/checkpoint_recovery_ctrl.sv
// Mispredict recovery sequencer: recall checkpoint, pulse restore, redirect, hold flush.
// Optional RECOVERY_STATS_EN adds saturating recovery / stall-cycle counters.
module checkpoint_recovery_ctrl
    import checkpoint_recovery_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_BR-1:0]     br_valid,
    input  logic [NUM_BR-1:0]     br_mispredict,
    input  logic [NUM_BR*CKW-1:0] br_cp_id,
    input  logic [NUM_BR*32-1:0]  br_target,
    input  logic [CKW-1:0]        cp_front,
    input  logic [LINE_SIZE-1:0]  recalled_data,
    output logic [NUM_BR-1:0]     validate,
    output logic [NUM_BR*CKW-1:0] validated_id,
    output logic                  recall_ckpt,
    output logic [CKW-1:0]        recall_id,
    output logic                  restore_valid,
    output logic [32*PRW-1:0]     rmt_restore,
    output logic [PRW-1:0]        fl_front_rst,
    output logic [ALW-1:0]        al_front_rst,
    output logic [NUM_PR-1:0]     bbt_rst,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  flush,
    output logic                  recovery_stall
`ifdef RECOVERY_STATS_EN
    ,
    output logic [31:0]           stat_recoveries,
    output logic [31:0]           stat_stall_cyc
`endif
);

    localparam int unsigned FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    recov_state_e   state_q, state_d;
    logic [CKW-1:0] tgt_id_q, tgt_id_d;
    logic [31:0]    tgt_pc_q, tgt_pc_d;
    logic [CKW-1:0] base_q, base_d;
    ckpt_line_t     line_q, line_d;
    logic [31:0]    redirect_pc_q, redirect_pc_d;
    logic [FCW-1:0] cnt_q, cnt_d;

    logic              busy;
    logic [CKW-1:0]    age_base;
    logic [CKW-1:0]    tgt_age;
    logic [NUM_BR-1:0] squashed;
    logic              sel_valid;
    logic [BRW-1:0]    sel_idx;
    logic [CKW-1:0]    sel_id;
    logic [CKW-1:0]    sel_age;
    logic [31:0]       sel_pc;
    logic              take;

    assign busy     = (state_q != IDLE);
    assign age_base = busy ? base_q : cp_front;
    assign tgt_age  = ckpt_age(age_base, tgt_id_q);

    always_comb begin
        squashed = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            squashed[i] = busy && (ckpt_age(age_base, br_cp_id[i*CKW +: CKW]) < tgt_age);
        end
    end

    ckpt_age_select u_sel (
        .base      (age_base),
        .req       (br_valid & br_mispredict & ~squashed),
        .ids       (br_cp_id),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .sel_id    (sel_id),
        .sel_age   (sel_age)
    );

    assign sel_pc = br_target[int'(sel_idx)*32 +: 32];
    // While busy only a strictly older mispredict preempts the pending target.
    assign take   = !reset && sel_valid && (!busy || sel_age > tgt_age);

    assign validate       = br_valid & ~br_mispredict & ~squashed & {NUM_BR{~reset}};
    assign validated_id   = br_cp_id;
    assign recovery_stall = !reset && (busy || take);
    assign recall_id      = tgt_id_q;
    assign rmt_restore    = line_q.rmt;
    assign fl_front_rst   = line_q.fl;
    assign al_front_rst   = line_q.al;
    assign bbt_rst        = line_q.bbt;
    assign redirect_pc    = redirect_pc_q;

    always_comb begin
        state_d        = state_q;
        tgt_id_d       = tgt_id_q;
        tgt_pc_d       = tgt_pc_q;
        base_d         = base_q;
        line_d         = line_q;
        redirect_pc_d  = redirect_pc_q;
        cnt_d          = cnt_q;
        recall_ckpt    = 1'b0;
        restore_valid  = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    tgt_id_d = sel_id;
                    tgt_pc_d = sel_pc;
                    base_d   = cp_front;
                    state_d  = RECALL;
                end
            end
            RECALL: begin
                recall_ckpt = 1'b1;
                if (!take) begin
                    line_d        = ckpt_line_t'(recalled_data);
                    redirect_pc_d = tgt_pc_q;
                    state_d       = RESTORE;
                end
            end
            RESTORE: begin
                flush          = 1'b1;
                restore_valid  = !take;
                redirect_valid = !take;
                state_d        = FLUSH;
                cnt_d          = FCW'(FLUSH_CYC - 1);
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (busy && take) begin
            tgt_id_d = sel_id;
            tgt_pc_d = sel_pc;
            state_d  = RECALL;
        end
        if (reset) begin
            recall_ckpt    = 1'b0;
            restore_valid  = 1'b0;
            redirect_valid = 1'b0;
            flush          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tgt_id_q      <= '0;
            tgt_pc_q      <= '0;
            base_q        <= '0;
            line_q        <= '0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            tgt_id_q      <= tgt_id_d;
            tgt_pc_q      <= tgt_pc_d;
            base_q        <= base_d;
            line_q        <= line_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
        end
    end

`ifdef RECOVERY_STATS_EN
    logic [31:0] stat_rec_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rec_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (restore_valid && stat_rec_q != '1) stat_rec_q <= stat_rec_q + 32'd1;
            if (recovery_stall && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_recoveries = stat_rec_q;
    assign stat_stall_cyc  = stat_stall_q;
`endif

endmodule

// File: tb/tb_checkpoint_recovery_ctrl.sv
// Scoreboard bench for checkpoint_recovery_ctrl: directed scenarios then random traffic.
module tb_checkpoint_recovery_ctrl;

    localparam int FLUSH_CYC = 2;

    typedef struct packed {
        logic [1:0] val;
        logic       rc;
        logic       rv;
        logic       fl;
        logic       st;
        logic [5:0] vid;
    } cyc_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  id;
    } rest_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   br_valid = '0, br_mispredict = '0;
    logic [5:0]   br_cp_id = '0;
    logic [63:0]  br_target = '0;
    logic [2:0]   cp_front = '0;
    logic [267:0] recalled_data;
    logic [1:0]   validate;
    logic [5:0]   validated_id;
    logic         recall_ckpt, restore_valid, redirect_valid, flush, recovery_stall;
    logic [2:0]   recall_id;
    logic [191:0] rmt_restore;
    logic [5:0]   fl_front_rst, al_front_rst;
    logic [63:0]  bbt_rst;
    logic [31:0]  redirect_pc;
`ifdef RECOVERY_STATS_EN
    logic [31:0]  stat_recoveries, stat_stall_cyc;
`endif

    logic [267:0] mem [8];
    assign recalled_data = mem[recall_id];

    int   n_chk = 0, n_fail = 0;
    cyc_t cyc_q[$];
    logic [2:0] recall_q[$];
    rest_t restore_q[$];

    int         m_phase = 0, m_left = 0;
    logic [2:0] m_tgt = '0, m_base = '0;
    logic [31:0] m_pc = '0;
    int         s_rec = 0, s_stall = 0;

    checkpoint_recovery_ctrl #(.FLUSH_CYC(FLUSH_CYC)) dut (
        .clk            (clk),
        .reset          (reset),
        .br_valid       (br_valid),
        .br_mispredict  (br_mispredict),
        .br_cp_id       (br_cp_id),
        .br_target      (br_target),
        .cp_front       (cp_front),
        .recalled_data  (recalled_data),
        .validate       (validate),
        .validated_id   (validated_id),
        .recall_ckpt    (recall_ckpt),
        .recall_id      (recall_id),
        .restore_valid  (restore_valid),
        .rmt_restore    (rmt_restore),
        .fl_front_rst   (fl_front_rst),
        .al_front_rst   (al_front_rst),
        .bbt_rst        (bbt_rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .recovery_stall (recovery_stall)
`ifdef RECOVERY_STATS_EN
        ,
        .stat_recoveries(stat_recoveries),
        .stat_stall_cyc (stat_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int age(int base, int id);
        return (base - 1 - id + 16) % 8;
    endfunction

    // Drive one cycle of inputs and predict that cycle's outputs from the recovery rules.
    task automatic tick(input bit rst, input bit [1:0] v, input bit [1:0] m,
                        input bit [2:0] i0, input bit [2:0] i1,
                        input bit [31:0] t0, input bit [31:0] t1, input bit [2:0] fr);
        cyc_t e;
        int ids[2];
        logic [31:0] tg[2];
        bit busy, take;
        int b, best;
        bit [1:0] sq;
        @(posedge clk);
        #1;
        reset = rst; br_valid = v; br_mispredict = m;
        br_cp_id = {i1, i0}; br_target = {t1, t0}; cp_front = fr;
        ids[0] = i0; ids[1] = i1; tg[0] = t0; tg[1] = t1;
        e = '0;
        e.vid = {i1, i0};
        if (rst) begin
            m_phase = 0; m_left = 0; m_tgt = '0; m_base = '0; m_pc = '0;
            s_rec = 0; s_stall = 0;
        end else begin
            busy = (m_phase != 0);
            b    = busy ? int'(m_base) : int'(fr);
            best = -1;
            for (int i = 0; i < 2; i++) begin
                sq[i] = busy && (age(b, ids[i]) < age(b, m_tgt));
                e.val[i] = v[i] && !m[i] && !sq[i];
                if (v[i] && m[i] && !sq[i] && (best < 0 || age(b, ids[i]) > age(b, ids[best])))
                    best = i;
            end
            take = (best >= 0) && (!busy || age(b, ids[best]) > age(b, m_tgt));
            e.st = busy || take;
            e.fl = (m_phase == 2) || (m_phase == 3);
            e.rc = (m_phase == 1);
            e.rv = (m_phase == 2) && !take;
            if (e.rc) recall_q.push_back(m_tgt);
            if (e.rv) begin
                restore_q.push_back('{pc: m_pc, id: m_tgt});
                s_rec++;
            end
            if (e.st) s_stall++;
            if (take) begin
                m_tgt = 3'(ids[best]);
                m_pc  = tg[best];
                if (!busy) m_base = fr;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 3;
                m_left  = FLUSH_CYC;
            end else if (m_phase == 3) begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        end
        cyc_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit [2:0] fr);
        for (int k = 0; k < n; k++) tick(0, 2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, fr);
    endtask

    // Monitor: per-cycle strobe checks plus payload checks whenever the DUT presents one.
    initial begin
        cyc_t e;
        logic [2:0] rid;
        rest_t r;
        logic [267:0] ln;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("validate", 512'(validate), 512'(e.val));
                chk("validated_id", 512'(validated_id), 512'(e.vid));
                chk("recall_ckpt", 512'(recall_ckpt), 512'(e.rc));
                chk("restore_valid", 512'(restore_valid), 512'(e.rv));
                chk("redirect_valid", 512'(redirect_valid), 512'(e.rv));
                chk("flush", 512'(flush), 512'(e.fl));
                chk("recovery_stall", 512'(recovery_stall), 512'(e.st));
                if (recall_ckpt) begin
                    if (recall_q.size() == 0) begin
                        chk("unexpected_recall", 512'(1), 512'(0));
                    end else begin
                        rid = recall_q.pop_front();
                        chk("recall_id", 512'(recall_id), 512'(rid));
                    end
                end
                if (restore_valid) begin
                    if (restore_q.size() == 0) begin
                        chk("unexpected_restore", 512'(1), 512'(0));
                    end else begin
                        r  = restore_q.pop_front();
                        ln = mem[r.id];
                        chk("redirect_pc", 512'(redirect_pc), 512'(r.pc));
                        chk("fl_front_rst", 512'(fl_front_rst), 512'(ln[5:0]));
                        chk("al_front_rst", 512'(al_front_rst), 512'(ln[11:6]));
                        chk("bbt_rst", 512'(bbt_rst), 512'(ln[75:12]));
                        chk("rmt_restore", 512'(rmt_restore), 512'(ln[267:76]));
                    end
                end
            end
        end
    end

    initial begin
        bit [1:0] v, m;
        bit [2:0] fr;
        logic [267:0] pat;
        for (int k = 0; k < 8; k++) begin
            mem[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom};
        end
        pat = '0;
        pat[5:0]   = 6'h2A;
        pat[11:6]  = 6'h11;
        pat[75:12] = 64'hAAAA_AAAA_AAAA_AAAA;
        for (int i = 0; i < 32; i++) pat[76 + i*6 +: 6] = 6'(i);
        mem[5] = pat;

        // Reset state
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 3'd0);
        @(negedge clk); #1;
        chk("rst_fields", 512'({rmt_restore, bbt_rst, al_front_rst, fl_front_rst}), 512'(0));
        chk("rst_redirect_pc", 512'(redirect_pc), 512'(0));

        // Single mispredict
        tick(0, 2'b01, 2'b01, 3'd3, 3'd0, 32'h1000, 32'h0, 3'd5);
        idle(6, 3'd5);
        // Dual mispredict, then a validate of the younger id while recovering
        tick(0, 2'b11, 2'b11, 3'd0, 3'd7, 32'h2000, 32'h2700, 3'd2);
        tick(0, 2'b01, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 3'd3);
        idle(6, 3'd3);
        // Preemption during FLUSH
        tick(0, 2'b01, 2'b01, 3'd4, 3'd0, 32'h4000, 32'h0, 3'd6);
        idle(2, 3'd6);
        tick(0, 2'b10, 2'b10, 3'd0, 3'd2, 32'h0, 32'h2222, 3'd6);
        idle(7, 3'd6);
        // Wrap-around ages; then squashed and older validates
        tick(0, 2'b11, 2'b11, 3'd0, 3'd6, 32'h3000, 32'h3600, 3'd1);
        tick(0, 2'b11, 2'b00, 3'd0, 3'd1, 32'h0, 32'h0, 3'd1);
        tick(0, 2'b01, 2'b00, 3'd7, 3'd0, 32'h0, 32'h0, 3'd1);
        idle(6, 3'd1);
        // Field unpack
        tick(0, 2'b01, 2'b01, 3'd5, 3'd0, 32'h5555, 32'h0, 3'd7);
        idle(6, 3'd7);
        // Preemption in RESTORE suppresses the pulse
        tick(0, 2'b01, 2'b01, 3'd4, 3'd0, 32'h4400, 32'h0, 3'd6);
        idle(1, 3'd6);
        tick(0, 2'b01, 2'b01, 3'd1, 3'd0, 32'h1100, 32'h0, 3'd6);
        idle(7, 3'd6);
        // Reset during RESTORE
        tick(0, 2'b01, 2'b01, 3'd2, 3'd0, 32'h2020, 32'h0, 3'd4);
        idle(1, 3'd4);
        tick(1, 0, 0, 0, 0, 0, 0, 3'd4);
        idle(1, 3'd4);
        @(negedge clk); #1;
        chk("rst2_fields", 512'({rmt_restore, bbt_rst, al_front_rst, fl_front_rst}), 512'(0));
        chk("rst2_redirect_pc", 512'(redirect_pc), 512'(0));

        // Random traffic
        fr = 3'd0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) fr = 3'($urandom);
            v = 2'($urandom);
            m = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            tick(($urandom_range(0, 249) == 0), v, m, 3'($urandom), 3'($urandom),
                 $urandom, $urandom, fr);
        end
        idle(10, fr);
        @(negedge clk); #1;
        chk("recall_q_drained", 512'(recall_q.size()), 512'(0));
        chk("restore_q_drained", 512'(restore_q.size()), 512'(0));
`ifdef RECOVERY_STATS_EN
        chk("stat_recoveries", 512'(stat_recoveries), 512'(s_rec));
        chk("stat_stall_cyc", 512'(stat_stall_cyc), 512'(s_stall));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
